// File: rtl/rv32_pkg.sv
// Shared definitions for the multicycle RV32 control unit.
// Holds the base opcode constants, the controller state encoding and the
// encodings of the immediate-format, next-PC and write-back selects, plus
// the opcode classification record produced by opcode_decoder.
// Optional feature: TRAP_ILLEGAL_EN (see multicycle_controller.sv).
package rv32_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam int unsigned TIMEOUT_W = 8;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4,
    IMM_U    = 3'd5
  } imm_fmt_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_ALU   = 2'd2
  } pc_src_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef struct packed {
    logic isLoad;
    logic isStore;
    logic isBranch;
    logic isJal;
    logic isJalr;
    logic isAuipc;
    logic writesRd;
    logic isLegal;
  } op_class_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Bundle between the multicycle controller and the datapath/memory side.
// Inputs to the controller: instr (IR contents), mem_ready (access done),
// branch_taken (ALU compare result).
// Outputs from the controller: memory strobes (mem_req, mem_we,
// mem_is_fetch), register-load strobes (ir_write, pc_write, reg_write),
// datapath selects (pc_src, imm_fmt, alu_src_a, alu_src_b, wb_sel),
// trap status (trap, trap_cause) and the current state (state_o).
// master = controller side, slave = datapath/memory side.
interface multicycle_controller_if;

  logic [31:0] instr;
  logic        mem_ready;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_we;
  logic        mem_is_fetch;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic [2:0]  imm_fmt;
  logic        alu_src_a;
  logic        alu_src_b;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        trap;
  logic        trap_cause;
  logic [2:0]  state_o;

  modport master (
    input  instr, mem_ready, branch_taken,
    output mem_req, mem_we, mem_is_fetch, ir_write, pc_write, pc_src,
           imm_fmt, alu_src_a, alu_src_b, reg_write, wb_sel, trap,
           trap_cause, state_o
  );

  modport slave (
    output instr, mem_ready, branch_taken,
    input  mem_req, mem_we, mem_is_fetch, ir_write, pc_write, pc_src,
           imm_fmt, alu_src_a, alu_src_b, reg_write, wb_sel, trap,
           trap_cause, state_o
  );

endinterface

// File: rtl/opcode_decoder.sv
// Classifies an RV32 base opcode into the flags the controller (and the
// datapath) need, and selects the immediate format for it.
// Ports:
//   opcode_i  - instr[6:0]
//   class_o   - classification flags (load/store/branch/jal/jalr/auipc,
//               writes a destination register, opcode is legal)
//   imm_fmt_o - immediate format encoding (imm_fmt_e)
module opcode_decoder
  import rv32_pkg::*;
(
  input  logic [6:0] opcode_i,
  output op_class_t  class_o,
  output logic [2:0] imm_fmt_o
);

  // Pure lookup on the opcode; FENCE and OP are legal but carry no immediate,
  // SYSTEM is legal with an I-type immediate but never writes a register.
  always_comb begin
    class_o   = '0;
    imm_fmt_o = IMM_NONE;
    case (opcode_i)
      OPC_LOAD: begin
        class_o.isLoad   = 1'b1;
        class_o.writesRd = 1'b1;
        class_o.isLegal  = 1'b1;
        imm_fmt_o        = IMM_I;
      end
      OPC_OP_IMM: begin
        class_o.writesRd = 1'b1;
        class_o.isLegal  = 1'b1;
        imm_fmt_o        = IMM_I;
      end
      OPC_JALR: begin
        class_o.isJalr   = 1'b1;
        class_o.writesRd = 1'b1;
        class_o.isLegal  = 1'b1;
        imm_fmt_o        = IMM_I;
      end
      OPC_SYSTEM: begin
        class_o.isLegal  = 1'b1;
        imm_fmt_o        = IMM_I;
      end
      OPC_STORE: begin
        class_o.isStore  = 1'b1;
        class_o.isLegal  = 1'b1;
        imm_fmt_o        = IMM_S;
      end
      OPC_BRANCH: begin
        class_o.isBranch = 1'b1;
        class_o.isLegal  = 1'b1;
        imm_fmt_o        = IMM_B;
      end
      OPC_JAL: begin
        class_o.isJal    = 1'b1;
        class_o.writesRd = 1'b1;
        class_o.isLegal  = 1'b1;
        imm_fmt_o        = IMM_J;
      end
      OPC_LUI: begin
        class_o.writesRd = 1'b1;
        class_o.isLegal  = 1'b1;
        imm_fmt_o        = IMM_U;
      end
      OPC_AUIPC: begin
        class_o.isAuipc  = 1'b1;
        class_o.writesRd = 1'b1;
        class_o.isLegal  = 1'b1;
        imm_fmt_o        = IMM_U;
      end
      OPC_OP: begin
        class_o.writesRd = 1'b1;
        class_o.isLegal  = 1'b1;
      end
      OPC_FENCE: begin
        class_o.isLegal  = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM of a multicycle RV32 core:
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, with a TRAP sink.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - multicycle_controller_if.master (instr/mem_ready/branch_taken in,
//         strobes, selects, trap status and state out)
// Parameter MEM_TIMEOUT (1..255): consecutive unanswered mem_req cycles
// tolerated before the controller traps with trap_cause = 1.
// Macro TRAP_ILLEGAL_EN: when defined, an unknown opcode traps from EXEC
// with trap_cause = 0; otherwise it retires as a NOP and trap_cause is 1.
module multicycle_controller
  import rv32_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
)
(
  input  logic                           clk,
  input  logic                           rst,
  multicycle_controller_if.master        bus
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

  state_e               state_q;
  logic [TIMEOUT_W-1:0] waitCnt_q;
  op_class_t            cls;
  logic [2:0]           immFmt;
  logic                 timeoutHit;
  logic                 unusedInstr;

  opcode_decoder u_decoder (
    .opcode_i  (bus.instr[6:0]),
    .class_o   (cls),
    .imm_fmt_o (immFmt)
  );

  assign unusedInstr = ^bus.instr[31:7];

  // The counter holds the number of already-unanswered cycles, so the access
  // times out when this cycle is also unanswered and the count is one short.
  // A ready arriving in that very cycle still wins.
  assign timeoutHit = !bus.mem_ready && (waitCnt_q == TIMEOUT_LAST);

`ifdef TRAP_ILLEGAL_EN
  logic cause_q;

  // The trap cause is latched when the trap is taken and reads as zero
  // while reset is asserted.
  assign bus.trap_cause = rst ? 1'b0 : cause_q;
`else
  // Only timeouts can trap in this build, so the cause is fixed at one
  // outside reset.
  assign bus.trap_cause = !rst;
`endif

  assign bus.state_o = state_q;

  // State register and wait counter. The counter is cleared on every cycle
  // that is not a waiting FETCH/MEM cycle, which makes it zero whenever one
  // of those states is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      waitCnt_q <= '0;
`ifdef TRAP_ILLEGAL_EN
      cause_q   <= 1'b0;
`endif
    end else begin
      waitCnt_q <= '0;
      case (state_q)
        ST_FETCH: begin
          if (bus.mem_ready) begin
            state_q <= ST_DECODE;
          end else if (timeoutHit) begin
            state_q <= ST_TRAP;
`ifdef TRAP_ILLEGAL_EN
            cause_q <= 1'b1;
`endif
          end else begin
            waitCnt_q <= waitCnt_q + 1'b1;
          end
        end
        ST_DECODE: begin
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (cls.isBranch) begin
            state_q <= ST_FETCH;
          end else if (cls.isLoad || cls.isStore) begin
            state_q <= ST_MEM;
          end else if (!cls.isLegal) begin
`ifdef TRAP_ILLEGAL_EN
            state_q <= ST_TRAP;
            cause_q <= 1'b0;
`else
            state_q <= ST_WB;
`endif
          end else begin
            state_q <= ST_WB;
          end
        end
        ST_MEM: begin
          if (bus.mem_ready) begin
            state_q <= cls.isStore ? ST_FETCH : ST_WB;
          end else if (timeoutHit) begin
            state_q <= ST_TRAP;
`ifdef TRAP_ILLEGAL_EN
            cause_q <= 1'b1;
`endif
          end else begin
            waitCnt_q <= waitCnt_q + 1'b1;
          end
        end
        ST_WB: begin
          state_q <= ST_FETCH;
        end
        ST_TRAP: begin
          state_q <= ST_TRAP;
        end
        default: begin
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

  // Output decode from the current state and opcode. The access-completing
  // strobes (ir_write, store pc_write) and the branch PC select follow the
  // handshake inputs combinationally so they land in the completing cycle.
  // Reset overrides everything to zero, even in the middle of an access.
  always_comb begin
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_is_fetch = 1'b0;
    bus.ir_write     = 1'b0;
    bus.pc_write     = 1'b0;
    bus.pc_src       = PC_PLUS4;
    bus.imm_fmt      = IMM_NONE;
    bus.alu_src_a    = 1'b0;
    bus.alu_src_b    = 1'b0;
    bus.reg_write    = 1'b0;
    bus.wb_sel       = WB_ALU;
    bus.trap         = 1'b0;
    if (!rst) begin
      if (state_q inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
        bus.imm_fmt = immFmt;
      end
      case (state_q)
        ST_FETCH: begin
          bus.mem_req      = 1'b1;
          bus.mem_is_fetch = 1'b1;
          bus.ir_write     = bus.mem_ready;
        end
        ST_EXEC: begin
          if (cls.isBranch) begin
            bus.pc_write = 1'b1;
            bus.pc_src   = bus.branch_taken ? PC_IMM : PC_PLUS4;
          end else if (cls.isLoad || cls.isStore) begin
            bus.alu_src_b = 1'b1;
          end else if (cls.isAuipc) begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 1'b1;
          end
        end
        ST_MEM: begin
          bus.mem_req = 1'b1;
          bus.mem_we  = cls.isStore;
          if (cls.isStore && bus.mem_ready) begin
            bus.pc_write = 1'b1;
            bus.pc_src   = PC_PLUS4;
          end
        end
        ST_WB: begin
          bus.pc_write  = 1'b1;
          bus.reg_write = cls.writesRd;
          if (cls.isJal) begin
            bus.pc_src = PC_IMM;
          end else if (cls.isJalr) begin
            bus.pc_src = PC_ALU;
          end
          if (cls.isLoad) begin
            bus.wb_sel = WB_MEM;
          end else if (cls.isJal || cls.isJalr) begin
            bus.wb_sel = WB_PC4;
          end
        end
        ST_TRAP: begin
          bus.trap = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller.
// A reference model turns each instruction (opcode, branch outcome, memory
// wait counts) into the cycle-by-cycle list of expected outputs and the
// mem_ready value to drive in that cycle; each test task replays such a list.
module tb_multicycle_controller;

  localparam int TIMEOUT = 15;

`ifdef TRAP_ILLEGAL_EN
  localparam bit TRAP_ILL = 1'b1;
`else
  localparam bit TRAP_ILL = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] st;
    logic       memReq;
    logic       memWe;
    logic       isFetch;
    logic       irWrite;
    logic       pcWrite;
    logic       regWrite;
    logic [1:0] pcSrc;
    logic [1:0] wbSel;
    logic [2:0] immFmt;
    logic       srcA;
    logic       srcB;
    logic       trap;
  } outVec;

  typedef struct packed {
    logic  rst;
    logic  rdy;
    logic  cause;
    outVec o;
  } cycRec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] curInstr = 32'h0;
  logic        curTaken = 1'b0;
  cycRec       trace[$];
  int          compared = 0;
  int          mismatched = 0;

  multicycle_controller_if bus();

  multicycle_controller #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Immediate format of an opcode, straight from the format table.
  function automatic logic [2:0] fmtOf(logic [6:0] op);
    case (op)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: return 3'd1;
      7'b0100011: return 3'd2;
      7'b1100011: return 3'd3;
      7'b1101111: return 3'd4;
      7'b0110111, 7'b0010111: return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic bit legalOp(logic [6:0] op);
    return (fmtOf(op) != 3'd0) || (op == 7'b0110011) || (op == 7'b0001111);
  endfunction

  function automatic void pushCyc(bit rstV, bit rdy, bit cause, outVec o);
    cycRec c;
    c.rst   = rstV;
    c.rdy   = rdy;
    c.cause = cause;
    c.o     = o;
    trace.push_back(c);
  endfunction

  // Twenty trap cycles, then two reset cycles (state still TRAP in the
  // first, FETCH in the second) that return the controller to service.
  function automatic void trapTail(bit cause);
    outVec v;
    for (int i = 0; i < 20; i++) begin
      v = '0; v.st = 3'd5; v.trap = 1'b1;
      pushCyc(1'b0, 1'($urandom), cause, v);
    end
    v = '0; v.st = 3'd5;
    pushCyc(1'b1, 1'($urandom), 1'b0, v);
    v = '0;
    pushCyc(1'b1, 1'($urandom), 1'b0, v);
  endfunction

  // Expected life of one instruction. fw/mw are the unanswered cycles before
  // mem_ready in FETCH/MEM; a value of TIMEOUT or more means never answered.
  function automatic void buildTrace(logic [6:0] op, bit taken, int fw, int mw);
    outVec v;
    logic [2:0] f = fmtOf(op);
    bit ld  = (op == 7'b0000011);
    bit stq = (op == 7'b0100011);
    bit jal = (op == 7'b1101111);
    bit jr  = (op == 7'b1100111);
    bit wr  = op inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                         7'b1101111, 7'b1100111, 7'b0000011};
    int fetchWait = (fw >= TIMEOUT) ? TIMEOUT : fw;
    for (int i = 0; i <= fetchWait; i++) begin
      if (i == TIMEOUT) begin
        trapTail(1'b1);
        return;
      end
      v = '0; v.memReq = 1'b1; v.isFetch = 1'b1; v.irWrite = (i == fw);
      pushCyc(1'b0, (i == fw), 1'b0, v);
    end
    v = '0; v.st = 3'd1; v.immFmt = f;
    pushCyc(1'b0, 1'($urandom), 1'b0, v);
    v = '0; v.st = 3'd2; v.immFmt = f;
    if (op == 7'b1100011) begin
      v.pcWrite = 1'b1; v.pcSrc = taken ? 2'd1 : 2'd0;
      pushCyc(1'b0, 1'($urandom), 1'b0, v);
      return;
    end
    if (ld || stq) v.srcB = 1'b1;
    if (op == 7'b0010111) begin v.srcA = 1'b1; v.srcB = 1'b1; end
    pushCyc(1'b0, 1'($urandom), 1'b0, v);
    if (!legalOp(op) && TRAP_ILL) begin
      trapTail(1'b0);
      return;
    end
    if (ld || stq) begin
      for (int i = 0; i <= mw; i++) begin
        if (i == TIMEOUT) begin
          trapTail(1'b1);
          return;
        end
        v = '0; v.st = 3'd3; v.memReq = 1'b1; v.memWe = stq; v.immFmt = f;
        if (i == mw && stq) v.pcWrite = 1'b1;
        pushCyc(1'b0, (i == mw), 1'b0, v);
      end
      if (stq) return;
    end
    v = '0; v.st = 3'd4; v.immFmt = f; v.pcWrite = 1'b1; v.regWrite = wr;
    v.pcSrc = jal ? 2'd1 : (jr ? 2'd2 : 2'd0);
    v.wbSel = ld ? 2'd1 : ((jal || jr) ? 2'd2 : 2'd0);
    pushCyc(1'b0, 1'($urandom), 1'b0, v);
  endfunction

  function automatic outVec observe();
    outVec v;
    v.st       = bus.state_o;
    v.memReq   = bus.mem_req;
    v.memWe    = bus.mem_we;
    v.isFetch  = bus.mem_is_fetch;
    v.irWrite  = bus.ir_write;
    v.pcWrite  = bus.pc_write;
    v.regWrite = bus.reg_write;
    v.pcSrc    = bus.pc_src;
    v.wbSel    = bus.wb_sel;
    v.immFmt   = bus.imm_fmt;
    v.srcA     = bus.alu_src_a;
    v.srcB     = bus.alu_src_b;
    v.trap     = bus.trap;
    return v;
  endfunction

  // Drives one cycle's inputs just after the rising edge and returns at the
  // falling edge, where the outputs are sampled.
  task automatic applyStimulus(input cycRec r);
    @(posedge clk);
    #1;
    rst              = r.rst;
    bus.mem_ready    = r.rdy;
    bus.instr        = curInstr;
    bus.branch_taken = curTaken;
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycRec r;
    outVec obs;
    int n = 0;
    outVec z = '0;
    for (int i = 0; i < 3; i++) pushCyc(1'b1, 1'($urandom), 1'b0, z);
    curInstr = 32'h0000_0003;
    curTaken = 1'b1;
    while (trace.size() > 0) begin
      r = trace.pop_front();
      applyStimulus(r);
      obs = observe();
      compared++;
      if (obs !== r.o) begin
        mismatched++;
        $display("[TB] FAIL reset row %0d: outputs %h, expected %h", n, obs, r.o);
      end
      if (r.o.trap || r.rst) begin
        compared++;
        if (bus.trap_cause !== r.cause) begin
          mismatched++;
          $display("[TB] FAIL reset row %0d trap_cause: got %b, expected %b", n, bus.trap_cause, r.cause);
        end
      end
      n++;
    end
  endtask

  task automatic test_addi();
    cycRec r;
    outVec obs;
    int n = 0;
    curInstr = 32'h0050_0093;
    curTaken = 1'b0;
    buildTrace(curInstr[6:0], 1'b0, 0, 0);
    buildTrace(curInstr[6:0], 1'b0, 0, 0);
    while (trace.size() > 0) begin
      r = trace.pop_front();
      applyStimulus(r);
      obs = observe();
      compared++;
      if (obs !== r.o) begin
        mismatched++;
        $display("[TB] FAIL addi row %0d: outputs %h, expected %h", n, obs, r.o);
      end
      if (r.o.trap || r.rst) begin
        compared++;
        if (bus.trap_cause !== r.cause) begin
          mismatched++;
          $display("[TB] FAIL addi row %0d trap_cause: got %b, expected %b", n, bus.trap_cause, r.cause);
        end
      end
      n++;
    end
  endtask

  task automatic test_store_wait();
    cycRec r;
    outVec obs;
    int n = 0;
    curInstr = 32'h0011_2023;
    curTaken = 1'b0;
    buildTrace(curInstr[6:0], 1'b0, 1, 3);
    while (trace.size() > 0) begin
      r = trace.pop_front();
      applyStimulus(r);
      obs = observe();
      compared++;
      if (obs !== r.o) begin
        mismatched++;
        $display("[TB] FAIL store row %0d: outputs %h, expected %h", n, obs, r.o);
      end
      if (r.o.trap || r.rst) begin
        compared++;
        if (bus.trap_cause !== r.cause) begin
          mismatched++;
          $display("[TB] FAIL store row %0d trap_cause: got %b, expected %b", n, bus.trap_cause, r.cause);
        end
      end
      n++;
    end
  endtask

  task automatic test_branch();
    cycRec r;
    outVec obs;
    int n = 0;
    curInstr = 32'h0000_0463;
    for (int t = 1; t >= 0; t--) begin
      curTaken = 1'(t);
      buildTrace(curInstr[6:0], 1'(t), $urandom_range(0, 2), 0);
      while (trace.size() > 0) begin
        r = trace.pop_front();
        applyStimulus(r);
        obs = observe();
        compared++;
        if (obs !== r.o) begin
          mismatched++;
          $display("[TB] FAIL branch taken=%0d row %0d: outputs %h, expected %h", t, n, obs, r.o);
        end
        if (r.o.trap || r.rst) begin
          compared++;
          if (bus.trap_cause !== r.cause) begin
            mismatched++;
            $display("[TB] FAIL branch row %0d trap_cause: got %b, expected %b", n, bus.trap_cause, r.cause);
          end
        end
        n++;
      end
    end
  endtask

  task automatic test_illegal();
    cycRec r;
    outVec obs;
    int n = 0;
    curInstr = 32'h0000_007F;
    curTaken = 1'b0;
    buildTrace(curInstr[6:0], 1'b0, 0, 0);
    buildTrace(7'b0001111, 1'b0, 0, 0);
    while (trace.size() > 0) begin
      r = trace.pop_front();
      if (trace.size() == 3 && !TRAP_ILL) curInstr = 32'h0000_000F;
      applyStimulus(r);
      obs = observe();
      compared++;
      if (obs !== r.o) begin
        mismatched++;
        $display("[TB] FAIL illegal row %0d: outputs %h, expected %h", n, obs, r.o);
      end
      if (r.o.trap || r.rst) begin
        compared++;
        if (bus.trap_cause !== r.cause) begin
          mismatched++;
          $display("[TB] FAIL illegal row %0d trap_cause: got %b, expected %b", n, bus.trap_cause, r.cause);
        end
      end
      n++;
    end
  endtask

  task automatic test_timeout();
    cycRec r;
    outVec obs;
    int n = 0;
    curTaken = 1'b0;
    curInstr = 32'h0050_0093;
    buildTrace(7'b0010011, 1'b0, TIMEOUT, 0);
    buildTrace(7'b0010011, 1'b0, TIMEOUT - 1, 0);
    while (trace.size() > 0) begin
      r = trace.pop_front();
      applyStimulus(r);
      obs = observe();
      compared++;
      if (obs !== r.o) begin
        mismatched++;
        $display("[TB] FAIL fetch_timeout row %0d: outputs %h, expected %h", n, obs, r.o);
      end
      if (r.o.trap || r.rst) begin
        compared++;
        if (bus.trap_cause !== r.cause) begin
          mismatched++;
          $display("[TB] FAIL fetch_timeout row %0d trap_cause: got %b, expected %b", n, bus.trap_cause, r.cause);
        end
      end
      n++;
    end
    curInstr = 32'h0000_2083;
    buildTrace(7'b0000011, 1'b0, 0, TIMEOUT);
    buildTrace(7'b0000011, 1'b0, 0, TIMEOUT - 1);
    while (trace.size() > 0) begin
      r = trace.pop_front();
      applyStimulus(r);
      obs = observe();
      compared++;
      if (obs !== r.o) begin
        mismatched++;
        $display("[TB] FAIL mem_timeout row %0d: outputs %h, expected %h", n, obs, r.o);
      end
      if (r.o.trap || r.rst) begin
        compared++;
        if (bus.trap_cause !== r.cause) begin
          mismatched++;
          $display("[TB] FAIL mem_timeout row %0d trap_cause: got %b, expected %b", n, bus.trap_cause, r.cause);
        end
      end
      n++;
    end
  endtask

  task automatic test_reset_mid_access();
    cycRec r;
    outVec obs;
    int n = 0;
    outVec v;
    curInstr = 32'h0040_A103;
    curTaken = 1'b0;
    buildTrace(7'b0000011, 1'b0, 0, 3);
    for (int i = 0; i < 3; i++) void'(trace.pop_back());
    v = '0; v.st = 3'd3;
    pushCyc(1'b1, 1'b1, 1'b0, v);
    v = '0;
    pushCyc(1'b1, 1'b1, 1'b0, v);
    buildTrace(7'b0000011, 1'b0, 0, 1);
    while (trace.size() > 0) begin
      r = trace.pop_front();
      applyStimulus(r);
      obs = observe();
      compared++;
      if (obs !== r.o) begin
        mismatched++;
        $display("[TB] FAIL reset_mid_mem row %0d: outputs %h, expected %h", n, obs, r.o);
      end
      if (r.o.trap || r.rst) begin
        compared++;
        if (bus.trap_cause !== r.cause) begin
          mismatched++;
          $display("[TB] FAIL reset_mid_mem row %0d trap_cause: got %b, expected %b", n, bus.trap_cause, r.cause);
        end
      end
      n++;
    end
  endtask

  task automatic test_random();
    cycRec r;
    outVec obs;
    int n = 0;
    logic [6:0] ops [12] = '{7'b0000011, 7'b0001111, 7'b0010011, 7'b0010111,
                             7'b0100011, 7'b0110011, 7'b0110111, 7'b1100011,
                             7'b1100111, 7'b1101111, 7'b1110011, 7'b0110011};
    logic [6:0] op;
    int fw;
    int mw;
    for (int k = 0; k < 40; k++) begin
      int idx = $urandom_range(0, 13);
      if (idx < 12) begin
        op = ops[idx];
      end else begin
        op = 7'($urandom);
        while (legalOp(op)) op = 7'($urandom);
      end
      fw = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : $urandom_range(0, 4);
      mw = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : $urandom_range(0, 4);
      curInstr = {25'($urandom), op};
      curTaken = 1'($urandom);
      buildTrace(op, curTaken, fw, mw);
      while (trace.size() > 0) begin
        r = trace.pop_front();
        applyStimulus(r);
        obs = observe();
        compared++;
        if (obs !== r.o) begin
          mismatched++;
          $display("[TB] FAIL random op=%b row %0d: outputs %h, expected %h", op, n, obs, r.o);
        end
        if (r.o.trap || r.rst) begin
          compared++;
          if (bus.trap_cause !== r.cause) begin
            mismatched++;
            $display("[TB] FAIL random op=%b row %0d trap_cause: got %b, expected %b", op, n, bus.trap_cause, r.cause);
          end
        end
        n++;
      end
    end
  endtask

  // Runs every scenario in order, then prints the summary.
  initial begin
    bus.instr        = 32'h0;
    bus.mem_ready    = 1'b0;
    bus.branch_taken = 1'b0;
    test_reset();
    test_addi();
    test_store_wait();
    test_branch();
    test_illegal();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
